// File: rtl/param_seq_datapath.sv
// Self-sequencing register-file datapath: ALU plus iterative signed multiply/divide,
// started by a start/busy/done handshake and stepped by an internal T-state sequencer.
module param_seq_datapath #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    localparam int RAW     = $clog2(NUM_REGS)
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    input  logic [3:0]        op,
    input  logic [RAW-1:0]    rd,
    input  logic [RAW-1:0]    rs,
    input  logic [RAW-1:0]    rt,
    input  logic [DATA_W-1:0] imm,
    input  logic              imm_sel,
    input  logic              wr_en,
    input  logic [RAW-1:0]    wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [RAW-1:0]    dbg_sel,
    output logic [DATA_W-1:0] dbg_data,
    output logic              busy,
    output logic              done,
    output logic              div_zero,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out,
    output logic [2:0]        dbg_state
);
    localparam int SW = $clog2(DATA_W);
    localparam logic [SW-1:0] CNT_LAST = SW'(DATA_W - 1);
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                           OP_SHR = 4'd4, OP_SHRA = 4'd5, OP_SHL = 4'd6, OP_ROR = 4'd7,
                           OP_ROL = 4'd8, OP_NEG = 4'd9, OP_NOT = 4'd10, OP_MUL = 4'd11,
                           OP_DIV = 4'd12, OP_MFHI = 4'd13, OP_MFLO = 4'd14, OP_LDI = 4'd15;

    typedef enum logic [2:0] {S_IDLE, S_LDY, S_EXEC, S_ITER, S_WB} state_t;
    state_t state_q, state_d;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [3:0]        op_q;
    logic [RAW-1:0]    rd_q, rs_q, rt_q;
    logic [DATA_W-1:0] imm_q, y_q, zhi_q, zlo_q, hi_q, lo_q, result_q, m_q;
    logic              imm_sel_q, neg_q, rneg_q, dz_q, done_q, div_zero_q;
    logic [SW-1:0]     cnt_q;
    logic              accept, is_md;

    logic [DATA_W-1:0] b_val, alu_out, a_abs, b_abs;
    logic [SW-1:0]     sh;
    logic [DATA_W:0]   mul_sum, div_shift, div_trial;
    logic [DATA_W-1:0] step_hi, step_lo, fin_hi, fin_lo, q_fix, r_fix;
    logic [2*DATA_W-1:0] prod_fix;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                accept  = 1'b1;
                state_d = S_LDY;
            end
            S_LDY:  state_d = S_EXEC;
            S_EXEC: state_d = is_md ? S_ITER : S_WB;
            S_ITER: if (cnt_q == CNT_LAST) state_d = S_WB;
            S_WB:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign is_md = (op_q == OP_MUL) || (op_q == OP_DIV);
    assign b_val = imm_sel_q ? imm_q : regs[rt_q];
    assign sh    = b_val[SW-1:0];
    assign a_abs = y_q[DATA_W-1] ? -y_q : y_q;
    assign b_abs = b_val[DATA_W-1] ? -b_val : b_val;

    always_comb begin
        alu_out = '0;
        case (op_q)
            OP_ADD:  alu_out = y_q + b_val;
            OP_SUB:  alu_out = y_q - b_val;
            OP_AND:  alu_out = y_q & b_val;
            OP_OR:   alu_out = y_q | b_val;
            OP_SHR:  alu_out = y_q >> sh;
            OP_SHRA: alu_out = $signed(y_q) >>> sh;
            OP_SHL:  alu_out = y_q << sh;
            OP_ROR:  alu_out = (y_q >> sh) | (y_q << (DATA_W - int'(sh)));
            OP_ROL:  alu_out = (y_q << sh) | (y_q >> (DATA_W - int'(sh)));
            OP_NEG:  alu_out = -b_val;
            OP_NOT:  alu_out = ~b_val;
            OP_MFHI: alu_out = hi_q;
            OP_MFLO: alu_out = lo_q;
            OP_LDI:  alu_out = imm_q;
            default: alu_out = '0;
        endcase
    end

    // Iteration works on magnitudes: MUL is shift-add over {zhi,zlo}, DIV is restoring
    // with zhi as remainder and zlo as quotient; signs are applied on the final step.
    always_comb begin
        mul_sum   = {1'b0, zhi_q} + (zlo_q[0] ? {1'b0, m_q} : '0);
        div_shift = {zhi_q, zlo_q[DATA_W-1]};
        div_trial = div_shift - {1'b0, m_q};
        if (op_q == OP_DIV) begin
            step_hi = div_trial[DATA_W] ? div_shift[DATA_W-1:0] : div_trial[DATA_W-1:0];
            step_lo = {zlo_q[DATA_W-2:0], ~div_trial[DATA_W]};
        end else begin
            step_hi = mul_sum[DATA_W:1];
            step_lo = {mul_sum[0], zlo_q[DATA_W-1:1]};
        end
        prod_fix = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
        q_fix    = neg_q ? -step_lo : step_lo;
        r_fix    = rneg_q ? -step_hi : step_hi;
        if (op_q == OP_DIV) begin
            fin_hi = dz_q ? y_q : r_fix;
            fin_lo = dz_q ? {DATA_W{1'b1}} : q_fix;
        end else begin
            fin_hi = prod_fix[2*DATA_W-1:DATA_W];
            fin_lo = prod_fix[DATA_W-1:0];
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            op_q <= '0; rd_q <= '0; rs_q <= '0; rt_q <= '0; imm_q <= '0; imm_sel_q <= 1'b0;
            y_q <= '0; zhi_q <= '0; zlo_q <= '0; hi_q <= '0; lo_q <= '0; result_q <= '0;
            m_q <= '0; neg_q <= 1'b0; rneg_q <= 1'b0; dz_q <= 1'b0; cnt_q <= '0;
            done_q <= 1'b0; div_zero_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                op_q <= op; rd_q <= rd; rs_q <= rs; rt_q <= rt;
                imm_q <= imm; imm_sel_q <= imm_sel; div_zero_q <= 1'b0;
            end
            case (state_q)
                S_LDY: y_q <= regs[rs_q];
                S_EXEC: begin
                    zhi_q <= '0;
                    if (is_md) begin
                        zlo_q  <= a_abs;
                        m_q    <= b_abs;
                        neg_q  <= y_q[DATA_W-1] ^ b_val[DATA_W-1];
                        rneg_q <= y_q[DATA_W-1];
                        dz_q   <= (b_val == '0);
                        cnt_q  <= '0;
                    end else begin
                        zlo_q <= alu_out;
                    end
                end
                S_ITER: begin
                    cnt_q <= cnt_q + 1'b1;
                    zhi_q <= (cnt_q == CNT_LAST) ? fin_hi : step_hi;
                    zlo_q <= (cnt_q == CNT_LAST) ? fin_lo : step_lo;
                end
                S_WB: begin
                    result_q <= zlo_q;
                    done_q   <= 1'b1;
                    if (is_md) begin
                        hi_q       <= zhi_q;
                        lo_q       <= zlo_q;
                        div_zero_q <= (op_q == OP_DIV) && dz_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // WB and host writes are mutually exclusive because host writes need IDLE.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (state_q == S_WB && !is_md) begin
            regs[rd_q] <= zlo_q;
        end else if (wr_en && state_q == S_IDLE) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign dbg_data  = regs[dbg_sel];
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign div_zero  = div_zero_q;
    assign result    = result_q;
    assign hi_out    = hi_q;
    assign lo_out    = lo_q;
    assign dbg_state = state_q;
endmodule

// File: doc/param_seq_datapath.md
Name: param_seq_datapath

Overview:
- Parametrised, self-sequencing successor to the Phase 1 bus datapath.
- Contains:
  - a NUM_REGS x DATA_W general register file;
  - Y, Zhigh/Zlow, HI and LO registers;
  - an ALU;
  - iterative signed multiply and divide units (no combinational array);
  - an internal micro-sequencer that runs the T-state steps itself.
- Replaces externally driven per-register in/out strobes with a start/busy/done handshake. Sits between the future control unit and the memory interface.

Parameters:
- DATA_W, 32, datapath width; power of two, >= 8.
- NUM_REGS, 16, number of general registers; power of two, >= 2.
- RAW, $clog2(NUM_REGS), register address width (derived; not overridden).

Ports:
- clock  in  1  rising-edge clock.
- clear  in  1  asynchronous active-high reset.
- start  in  1  request an operation; sampled only while busy=0.
- op  in  4  operation code (see Behaviour).
- rd  in  RAW  destination register.
- rs  in  RAW  source A register (loaded into Y).
- rt  in  RAW  source B register.
- imm  in  DATA_W  immediate operand.
- imm_sel  in  1  B operand = imm when 1, R[rt] when 0.
- wr_en  in  1  host register load (test/boot path).
- wr_addr  in  RAW  host load address.
- wr_data  in  DATA_W  host load data.
- dbg_sel  in  RAW  debug read address.
- dbg_data  out  DATA_W  combinational R[dbg_sel].
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- div_zero  out  1  valid with done: last DIV had divisor 0.
- result  out  DATA_W  value written back by the last op (LO for MUL/DIV); held until the next done.
- hi_out  out  DATA_W  HI register.
- lo_out  out  DATA_W  LO register.

Behaviour:
- Reset (clear=1, async):
  - all registers, Y, Z, HI, LO, result go to 0;
  - state goes to IDLE; busy=0, done=0, div_zero=0.
  - Asserting clear mid-operation abandons the op with no writeback.
- Op codes:
  - 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 SHR logical, 5 SHRA, 6 SHL, 7 ROR, 8 ROL;
  - 9 NEG (-B), 10 NOT (~B);
  - 11 MUL, 12 DIV;
  - 13 MFHI (rd<=HI), 14 MFLO (rd<=LO), 15 LDI (rd<=imm, ignores imm_sel).
  - A = Y = R[rs]. Shift/rotate amount = B[$clog2(DATA_W)-1:0].
  - All arithmetic wraps modulo 2^DATA_W; there are no flags.
- Handshake:
  - start is accepted on a rising edge with busy=0. op/rd/rs/rt/imm/imm_sel are captured at acceptance; later changes are ignored.
  - busy rises the cycle after acceptance.
  - start while busy=1 is ignored, with no queueing.
- States:
  - IDLE: waits for start.
  - LDY: Y <= R[rs].
  - EXEC: Zlow <= ALU(Y,B), Zhigh <= 0 (ops 0-10, 13-15). For MUL/DIV, EXEC loads the iteration registers and goes to ITER.
  - ITER: one radix-2 step per cycle for exactly DATA_W cycles, then WB.
  - WB: R[rd] <= Zlow and result <= Zlow. For MUL/DIV, HI <= Zhigh, LO <= Zlow, result <= Zlow, and no GPR write.
  - Next state after WB is IDLE, with done=1 for exactly that one cycle and busy=0 in that cycle.
- Latency:
  - ALU op: busy high for 3 cycles, done on the 4th cycle after acceptance.
  - MUL/DIV: busy high for 3+DATA_W cycles.
- MUL: signed x signed; 2*DATA_W-bit product; Zhigh = upper half, Zlow = lower half.
- DIV: signed; quotient truncates toward zero; remainder takes the sign of the dividend. HI = remainder, LO = quotient.
  - Divisor 0: LO = all ones, HI = dividend, div_zero = 1 with done.
  - MIN_INT / -1: LO = MIN_INT, HI = 0, div_zero = 0.
  - div_zero is cleared at the next accepted start.
- Host write port:
  - wr_en is honoured only while busy=0 and no WB occurs that edge; otherwise it is dropped.
  - wr_en together with an accepted start on the same edge is allowed: the write lands at that edge and LDY reads the new value.
- Same-register cases: rd may equal rs or rt. Sources are read before WB, so the result overwrites.
- dbg_data reflects a register write from the cycle after the write edge.

Test Plan:
- Reset then dbg sweep of all regs: every read = 0. Assert clear during ITER of a MUL: busy=0, done never pulses, HI/LO = 0.
- Host-load R1=0x00000005, R2=0xFFFFFFFD (-3); ADD rd=3, rs=1, rt=2: done 4 cycles after start, R3=0x00000002, result=0x00000002.
- MUL R1×R2 (5×-3), DATA_W=32: busy exactly 35 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFF1, no GPR changes.
- DIV 0xFFFFFFF9 (-7) by 2: LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV by 0: LO=0xFFFFFFFF, HI=dividend, div_zero=1. DIV 0x80000000 by -1: LO=0x80000000, HI=0.
- SHRA 0x80000010 by imm=4 (imm_sel=1): 0xF8000001. ROL 0x80000001 by 1: 0x00000003. Shift by imm=33: amount 1.
- start pulsed every cycle during a MUL plus wr_en mid-op: no extra ops, write dropped, exactly one done. Back-to-back start on the done cycle: accepted.
- Repeat ADD/MUL with DATA_W=16, NUM_REGS=8: MUL busy 19 cycles, results correct mod 2^16.
